// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS32 control FSM: sequences fetch/decode/exec/mem/write-back around
// a shared ALU and a single memory port, with illegal-opcode and memory-timeout traps.
module mips_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             branch,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic [1:0]       mem_size,
   output logic             mem_addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             alu_latch,
   output logic             regfile_we,
   output logic             wb_sel,
   output logic             illegal,
   output logic             bus_err,
   output logic             busy,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BGEZ = 6'b000001;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LB   = 6'b100000;
   localparam logic [5:0] OP_LH   = 6'b100001;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SB   = 6'b101000;
   localparam logic [5:0] OP_SH   = 6'b101001;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   logic [2:0]        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              is_load, is_store, is_branch, is_alu, legal;
   logic              waiting, timeout, retire;

   always_comb begin
      is_load   = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW);
      is_store  = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
      is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_BGEZ);
      is_alu    = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                  (opcode == OP_SLTI) ||
                  ((opcode == OP_R) && ((funct == 6'b100000) || (funct == 6'b100010) ||
                                        (funct == 6'b100100) || (funct == 6'b100101) ||
                                        (funct == 6'b100111) || (funct == 6'b101010)));
      legal     = is_load || is_store || is_branch || is_alu;
   end

   assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
   assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
   assign busy    = (state != S_IDLE) && (state != S_HALT);

   always_comb begin
      state_nxt    = state;
      retire       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_size     = 2'b00;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      alu_latch    = 1'b0;
      regfile_we   = 1'b0;
      wb_sel       = 1'b0;
      case (state)
         S_IDLE: if (start) state_nxt = S_FETCH;
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_size = 2'b10;
            if (mem_ready) begin
               ir_we     = 1'b1;
               state_nxt = S_DECODE;
            end else if (timeout) begin
               state_nxt = S_HALT;
            end
         end
         S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
         S_EXEC: begin
            alu_latch = 1'b1;
            if (is_branch) begin
               pc_we     = 1'b1;
               pc_sel    = branch;
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end else if (is_load || is_store) begin
               state_nxt = S_MEM;
            end else begin
               state_nxt = S_WB;
            end
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = is_store;
            // opcode[1:0] is 00 byte, 01 half, 11 word for both loads and stores
            mem_size     = opcode[1] ? 2'b10 : {1'b0, opcode[0]};
            if (mem_ready) begin
               if (is_store) begin
                  pc_we     = 1'b1;
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (timeout) begin
               state_nxt = S_HALT;
            end
         end
         S_WB: begin
            regfile_we = 1'b1;
            wb_sel     = is_load;
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
      // Reset must never leak a partial request, PC update or write-back.
      if (reset) begin
         retire       = 1'b0;
         mem_req      = 1'b0;
         mem_we       = 1'b0;
         mem_size     = 2'b00;
         mem_addr_sel = 1'b0;
         ir_we        = 1'b0;
         pc_we        = 1'b0;
         pc_sel       = 1'b0;
         alu_latch    = 1'b0;
         regfile_we   = 1'b0;
         wb_sel       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         illegal     <= 1'b0;
         bus_err     <= 1'b0;
         instr_count <= '0;
         wait_cnt    <= '0;
      end else begin
         state <= state_nxt;
         if ((state == S_DECODE) && !legal) illegal <= 1'b1;
         if (timeout) bus_err <= 1'b1;
         if (retire) instr_count <= instr_count + 1'b1;
         // Every entry into FETCH/MEM is a state change, so clearing on change suffices.
         if (state_nxt != state) wait_cnt <= '0;
         else if (waiting)       wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_mips_multicycle_ctrl;

   typedef struct packed {
      logic [2:0]  st;
      logic [10:0] strb;
      logic        ill;
      logic        berr;
      logic        bsy;
      logic [31:0] cnt;
   } exp_t;

   // strobe order: req, we, size[1:0], addr_sel, ir_we, pc_we, pc_sel, alu_latch, rf_we, wb_sel
   localparam logic [10:0] N    = 11'b00000000000;
   localparam logic [10:0] F    = 11'b10100000000;
   localparam logic [10:0] FR   = 11'b10100100000;
   localparam logic [10:0] E    = 11'b00000000100;
   localparam logic [10:0] EB1  = 11'b00000011100;
   localparam logic [10:0] EB0  = 11'b00000010100;
   localparam logic [10:0] MLW  = 11'b10101000000;
   localparam logic [10:0] MSB  = 11'b11001010000;
   localparam logic [10:0] MSH  = 11'b11011010000;
   localparam logic [10:0] WBA  = 11'b00000010010;
   localparam logic [10:0] WBL  = 11'b00000010011;

   logic        clk = 1'b0;
   logic        reset, start, branch, mem_ready;
   logic [5:0]  opcode, funct;
   logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_latch;
   logic        regfile_we, wb_sel, illegal, bus_err, busy;
   logic [1:0]  mem_size;
   logic [2:0]  state;
   logic [31:0] instr_count;

   exp_t  q[$];
   string nq[$];
   int    checks = 0;
   int    passed = 0;

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
      .branch(branch), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_size(mem_size), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we),
      .pc_sel(pc_sel), .alu_latch(alu_latch), .regfile_we(regfile_we), .wb_sel(wb_sel),
      .illegal(illegal), .bus_err(bus_err), .busy(busy), .state(state),
      .instr_count(instr_count)
   );

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t  e;
         exp_t  a;
         string n;
         e = q.pop_front();
         n = nq.pop_front();
         a = '{st: state,
               strb: {mem_req, mem_we, mem_size, mem_addr_sel, ir_we, pc_we, pc_sel,
                      alu_latch, regfile_we, wb_sel},
               ill: illegal, berr: bus_err, bsy: busy, cnt: instr_count};
         checks++;
         if (a !== e)
            $display("FAIL %s: got st=%0d strb=%b ill=%b berr=%b busy=%b cnt=%0d, want st=%0d strb=%b ill=%b berr=%b busy=%b cnt=%0d",
                     n, a.st, a.strb, a.ill, a.berr, a.bsy, a.cnt,
                     e.st, e.strb, e.ill, e.berr, e.bsy, e.cnt);
         else
            passed++;
      end
   end

   task automatic ins(input logic [5:0] op, input logic [5:0] fn, input logic br);
      opcode = op;
      funct  = fn;
      branch = br;
   endtask

   // One clock of stimulus plus the outputs expected during that clock.
   task automatic cyc(input string nm, input logic rst, input logic st_in, input logic rdy,
                      input logic [2:0] es, input logic [10:0] esb,
                      input logic eill, input logic eberr, input int ecnt);
      exp_t e;
      reset     = rst;
      start     = st_in;
      mem_ready = rdy;
      e = '{st: es, strb: esb, ill: eill, berr: eberr,
            bsy: (es != 3'd0) && (es != 3'd6), cnt: 32'(ecnt)};
      q.push_back(e);
      nq.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mem_ready = 1'b0;
      ins(6'b000000, 6'b100000, 1'b0);
      @(posedge clk);
      #1;
      cyc("reset",      1, 0, 0, 0, N, 0, 0, 0);
      cyc("idle",       0, 0, 1, 0, N, 0, 0, 0);
      cyc("idle_start", 0, 1, 0, 0, N, 0, 0, 0);
      // add: 1,2,3,5 then back to FETCH
      cyc("add_fetch",  0, 0, 1, 1, FR,  0, 0, 0);
      cyc("add_decode", 0, 0, 1, 2, N,   0, 0, 0);
      cyc("add_exec",   0, 0, 1, 3, E,   0, 0, 0);
      cyc("add_wb",     0, 0, 1, 5, WBA, 0, 0, 0);
      // lw with 3 wait cycles in MEM
      ins(6'b100011, 6'b000000, 1'b0);
      cyc("lw_fetch",   0, 0, 1, 1, FR, 0, 0, 1);
      cyc("lw_decode",  0, 0, 1, 2, N,  0, 0, 1);
      cyc("lw_exec",    0, 0, 1, 3, E,  0, 0, 1);
      for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 0, 0, 0, 4, MLW, 0, 0, 1);
      cyc("lw_mem_rdy", 0, 0, 1, 4, MLW, 0, 0, 1);
      cyc("lw_wb",      0, 0, 1, 5, WBL, 0, 0, 1);
      // beq taken, bne not taken
      ins(6'b000100, 6'b000000, 1'b1);
      cyc("beq_fetch",  0, 0, 1, 1, FR,  0, 0, 2);
      cyc("beq_decode", 0, 0, 1, 2, N,   0, 0, 2);
      cyc("beq_exec",   0, 0, 1, 3, EB1, 0, 0, 2);
      ins(6'b000101, 6'b000000, 1'b0);
      cyc("bne_fetch",  0, 0, 1, 1, FR,  0, 0, 3);
      cyc("bne_decode", 0, 0, 1, 2, N,   0, 0, 3);
      cyc("bne_exec",   0, 0, 1, 3, EB0, 0, 0, 3);
      // sb and sh: no WB cycle
      ins(6'b101000, 6'b000000, 1'b0);
      cyc("sb_fetch",   0, 0, 1, 1, FR,  0, 0, 4);
      cyc("sb_decode",  0, 0, 1, 2, N,   0, 0, 4);
      cyc("sb_exec",    0, 0, 1, 3, E,   0, 0, 4);
      cyc("sb_mem",     0, 0, 1, 4, MSB, 0, 0, 4);
      ins(6'b101001, 6'b000000, 1'b0);
      cyc("sh_fetch",   0, 0, 1, 1, FR,  0, 0, 5);
      cyc("sh_decode",  0, 0, 1, 2, N,   0, 0, 5);
      cyc("sh_exec",    0, 0, 1, 3, E,   0, 0, 5);
      cyc("sh_mem",     0, 0, 1, 4, MSH, 0, 0, 5);
      // lw with long waits in both FETCH and MEM: wait counter must clear on MEM entry
      ins(6'b100011, 6'b000000, 1'b0);
      for (int i = 0; i < 10; i++) cyc("lw2_fetch_wait", 0, 0, 0, 1, F, 0, 0, 6);
      cyc("lw2_fetch",  0, 0, 1, 1, FR, 0, 0, 6);
      cyc("lw2_decode", 0, 0, 1, 2, N,  0, 0, 6);
      cyc("lw2_exec",   0, 0, 1, 3, E,  0, 0, 6);
      for (int i = 0; i < 12; i++) cyc("lw2_mem_wait", 0, 0, 0, 4, MLW, 0, 0, 6);
      cyc("lw2_mem_rdy", 0, 0, 1, 4, MLW, 0, 0, 6);
      cyc("lw2_wb",      0, 0, 1, 5, WBL, 0, 0, 6);
      // illegal opcode 111111
      ins(6'b111111, 6'b000000, 1'b0);
      cyc("ill_fetch",  0, 0, 1, 1, FR, 0, 0, 7);
      cyc("ill_decode", 0, 0, 1, 2, N,  0, 0, 7);
      cyc("ill_halt",   0, 1, 1, 6, N,  1, 0, 7);
      cyc("ill_halt2",  0, 1, 1, 6, N,  1, 0, 7);
      cyc("ill_reset",  1, 0, 0, 6, N,  1, 0, 7);
      cyc("ill_idle",   0, 0, 0, 0, N,  0, 0, 0);
      // R-type with unsupported funct 000000
      ins(6'b000000, 6'b000000, 1'b0);
      cyc("rfn_start",  0, 1, 0, 0, N,  0, 0, 0);
      cyc("rfn_fetch",  0, 0, 1, 1, FR, 0, 0, 0);
      cyc("rfn_decode", 0, 0, 1, 2, N,  0, 0, 0);
      cyc("rfn_halt",   0, 1, 0, 6, N,  1, 0, 0);
      cyc("rfn_reset",  1, 0, 0, 6, N,  1, 0, 0);
      cyc("rfn_idle",   0, 0, 0, 0, N,  0, 0, 0);
      // reset mid-request and during write-back
      ins(6'b000000, 6'b100000, 1'b0);
      cyc("mid_start",  0, 1, 0, 1 - 1, N, 0, 0, 0);
      cyc("mid_fetch",  0, 0, 0, 1, F,  0, 0, 0);
      cyc("mid_reset",  1, 0, 1, 1, N,  0, 0, 0);
      cyc("mid_idle",   0, 1, 0, 0, N,  0, 0, 0);
      cyc("wbr_fetch",  0, 0, 1, 1, FR, 0, 0, 0);
      cyc("wbr_decode", 0, 0, 1, 2, N,  0, 0, 0);
      cyc("wbr_exec",   0, 0, 1, 3, E,  0, 0, 0);
      cyc("wbr_reset",  1, 0, 1, 5, N,  0, 0, 0);
      cyc("wbr_idle",   0, 0, 0, 0, N,  0, 0, 0);
      // FETCH timeout after 16 request cycles
      cyc("to_start",   0, 1, 0, 0, N,  0, 0, 0);
      for (int i = 0; i < 16; i++) cyc("to_fetch_wait", 0, 0, 0, 1, F, 0, 0, 0);
      cyc("to_halt",    0, 1, 0, 6, N,  0, 1, 0);
      cyc("to_reset",   1, 0, 0, 6, N,  0, 1, 0);
      cyc("to_idle",    0, 0, 0, 0, N,  0, 0, 0);
      // ready in the 16th cycle wins over the timeout
      cyc("rw_start",   0, 1, 0, 0, N,  0, 0, 0);
      for (int i = 0; i < 15; i++) cyc("rw_fetch_wait", 0, 0, 0, 1, F, 0, 0, 0);
      cyc("rw_fetch16", 0, 0, 1, 1, FR, 0, 0, 0);
      cyc("rw_decode",  0, 0, 0, 2, N,  0, 0, 0);
      cyc("rw_exec",    0, 0, 0, 3, E,  0, 0, 0);
      cyc("rw_wb",      0, 0, 0, 5, WBA, 0, 0, 0);
      cyc("rw_next",    0, 0, 0, 1, F,  0, 0, 1);
      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
